// File: rtl/ascon_permutation_core.sv
// Ascon p^a permutation core: UNROLL rounds per clock over a 320-bit state.
// Start/ready/valid handshake; illegal round counts are rejected with err_o.
module ascon_permutation_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  logic [319:0] state_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic         err_o,
  output logic [319:0] state_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [3:0] STEP = 4'(UNROLL);

  fsm_t         fsm, fsm_n;
  logic [319:0] st, nxt;
  logic [3:0]   rnd;
  logic         err;
  logic         legal, load, reject, step, last;

  function automatic logic [63:0] ror(
    input logic [63:0] x,
    input int          n
  );
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] round_fn(
    input logic [319:0] s,
    input logic [3:0]   i
  );
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'h0, 4'hf - i, i};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Unrolled chain: round k of this cycle uses index rnd+k.
  always_comb begin
    nxt = st;
    for (int k = 0; k < UNROLL; k++) begin
      nxt = round_fn(nxt, rnd + 4'(k));
    end
  end

  assign legal = (rounds_i != 4'd0)
              && (rounds_i <= 4'd12)
              && ((rounds_i % STEP) == 4'd0);
  assign last  = (rnd + STEP) == 4'd12;

  always_comb begin
    fsm_n  = fsm;
    load   = 1'b0;
    reject = 1'b0;
    step   = 1'b0;
    unique case (fsm)
      IDLE, DONE: begin
        fsm_n = IDLE;
        if (start_i && legal) begin
          load  = 1'b1;
          fsm_n = RUN;
        end else if (start_i) begin
          reject = 1'b1;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) fsm_n = DONE;
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= IDLE;
      st      <= '0;
      rnd     <= '0;
      err     <= 1'b0;
      state_o <= '0;
    end else begin
      fsm <= fsm_n;
      err <= reject;
      if (load) begin
        st  <= state_i;
        rnd <= 4'd12 - rounds_i;
      end else if (step) begin
        st  <= nxt;
        rnd <= rnd + STEP;
        if (last) state_o <= nxt;
      end
    end
  end

  assign ready_o = (fsm != RUN);
  assign valid_o = (fsm == DONE);
  assign err_o   = err;

endmodule

// File: doc/ascon_permutation_core.md
Name: ascon_permutation_core

Overview:
- Synthesizable RTL implementation of the Ascon permutation p^a, the hardware counterpart of the pc/ps/pl/p8/p12 golden C model.
- Iterates UNROLL rounds per clock over a 320-bit state register.
- Uses a start/ready/valid handshake and is shared by the AEAD128 initialization, data-processing and finalization phases.
- Each run is bit-exact against the DPI permutation(s, rnd) call with the same round count.

Parameters:
- UNROLL, 1, rounds computed per clock cycle; legal values are 1, 2 and 4.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start_i  input  1  request a permutation run; accepted only when ready_o=1
- rounds_i  input  4  number of rounds a, sampled on accept
- state_i  input  320  input state {s0,s1,s2,s3,s4}, with s0 in [319:256]; sampled on accept
- ready_o  output  1  core idle and able to accept start_i
- valid_o  output  1  one-cycle pulse when state_o holds a new result
- err_o  output  1  one-cycle pulse when a start is rejected for an illegal rounds_i
- state_o  output  320  result state, same word order as state_i

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - ready_o=1, valid_o=0, err_o=0.
  - state_o and the internal state register clear to 0; round counter clears to 0.
  - Reset takes effect mid-run: the run is abandoned and no valid_o is issued.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i=1 with a legal rounds_i:
  - Legal means 1 <= rounds_i <= 12 and rounds_i is a multiple of UNROLL.
  - State register <= state_i; round index r <= 12 - rounds_i; ready_o <= 0; go to RUN.
- IDLE, start_i=1 with an illegal rounds_i:
  - err_o pulses for 1 cycle.
  - Stays in IDLE, ready_o stays 1, state_o unchanged.
- RUN, each cycle:
  - Applies UNROLL consecutive rounds with indices r..r+UNROLL-1; r <= r + UNROLL.
  - When r + UNROLL = 12: write the result to state_o and go to DONE.
- DONE: lasts exactly 1 cycle. valid_o=1, ready_o=1, then go to IDLE.
  - A start_i seen during DONE is accepted exactly as in IDLE: back-to-back runs with no bubble.
  - In that case valid_o for the old run and the new run's load happen in the same cycle.
- Latency: accept edge to valid_o high = rounds_i/UNROLL + 1 cycles.
  - UNROLL=1: p12 = 13 cycles, p8 = 9 cycles.
- state_o holds its value from valid_o until the next valid_o; it is not cleared when a new run starts.
- start_i while in RUN is ignored: no error, no effect.
- Round i (0..11), applied in this order:
  - pc: s2 ^= {56'h0, c_i} with c_i = ((15-i)<<4) | i, i.e. i=0 -> 0xf0, i=4 -> 0xb4, i=11 -> 0x4b.
  - ps: bitsliced 5-bit S-box over the 64 columns, per the Ascon specification:
    - x0^=x4; x4^=x3; x2^=x1
    - t_k = ~x_k & x_(k+1 mod 5)
    - x_k ^= t_(k+1 mod 5)
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2
  - pl: s0^=ror(s0,19)^ror(s0,28); s1^=ror(s1,61)^ror(s1,39); s2^=ror(s2,1)^ror(s2,6); s3^=ror(s3,10)^ror(s3,17); s4^=ror(s4,7)^ror(s4,41).
- Widths and indexing:
  - All arithmetic is XOR/AND/NOT/rotate on 64-bit words; there are no adders apart from the 4-bit round counter.
  - The counter never exceeds 12.
  - Unrolled rounds are a combinational chain of identical round functions, each fed its own constant index.

Test Plan:
- Reset then idle: ready_o=1, valid_o=0, err_o=0, state_o=0.
- UNROLL=1, state_i=0, rounds_i=12:
  - valid_o exactly 13 cycles after accept; state_o equals DPI p12 of the all-zero state.
  - Repeat with rounds_i=8 and compare to DPI p8, valid_o at 9 cycles.
- Random state_i, rounds_i from 1 to 12 (UNROLL=1), and rounds_i in {4,8,12} (UNROLL=4):
  - Each result matches DPI permutation(s, rounds_i).
  - UNROLL=4, rounds_i=12 gives valid_o at cycle 4.
- Illegal round counts:
  - rounds_i=0, 13 or 15 -> err_o pulses 1 cycle, ready_o stays 1, no valid_o.
  - UNROLL=2 with rounds_i=7 -> same error response.
- Back-to-back: start_i held high with two different states (p12 then p8):
  - Second accept lands in the DONE cycle of the first run.
  - valid_o pulses at cycle 13 and cycle 22; both results match the DPI model.
- Reset asserted at cycle 5 of a p12 run:
  - No valid_o, ready_o=1 and state_o=0 on the next cycle.
  - A fresh p12 run afterwards is correct.
